assert_monitor: RTL



---
 rtl/assert_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/assert_monitor.sv
// Assertion-status aggregator: saturating error/warning totals, reset holdoff and sticky stop request.
// Optional build macro ASSERT_EXIT_ON_WARNING_EN lets the warning total also trip the stop request.
module assert_monitor #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int ERR_LIMIT  = 1,
  parameter int WARN_LIMIT = 8,
  parameter int HOLDOFF    = 16,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] err_pulse,
  input  logic [CHANNELS-1:0] warn_pulse,
  input  logic                clear,
  output logic [CNT_W-1:0]    errors,
  output logic [CNT_W-1:0]    warnings,
  output logic                message_on,
  output logic                stop_req,
  output logic [CH_W-1:0]     first_chan,
  output logic                warn_note,
  output logic [1:0]          state_o
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_TRIPPED = 2'd2;

  localparam int             SUM_W    = CNT_W + 7;
  localparam logic [15:0]    HOLD_LIM = 16'(HOLDOFF);
  localparam logic [CNT_W-1:0] ERR_LIM = CNT_W'(ERR_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] warn_q, warn_d;
  logic [CH_W-1:0]  first_q, first_d;
  logic             note_q, note_d;

  logic             hold_done;
  logic             count_en;
  logic             trip;
  logic [CH_W-1:0]  first_next;
  logic [SUM_W-1:0] err_sum, warn_sum;
  logic [CNT_W-1:0] err_sat, warn_sat;

  function automatic logic [6:0] popcnt(input logic [CHANNELS-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < CHANNELS; i++) n = n + {6'd0, v[i]};
    return n;
  endfunction

  // Scans downward so the lowest set index is the one left standing.
  function automatic logic [CH_W-1:0] lowest(input logic [CHANNELS-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    err_sum  = {7'd0, err_q} + {{CNT_W{1'b0}}, popcnt(err_pulse)};
    warn_sum = {7'd0, warn_q} + {{CNT_W{1'b0}}, popcnt(warn_pulse)};
    err_sat  = (err_sum > {7'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    warn_sat = (warn_sum > {7'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : warn_sum[CNT_W-1:0];
  end

`ifdef ASSERT_EXIT_ON_WARNING_EN
  localparam logic [CNT_W-1:0] WARN_LIM = CNT_W'(WARN_LIMIT);
  always_comb begin
    trip       = (err_sat >= ERR_LIM) || (warn_sat >= WARN_LIM);
    first_next = (|err_pulse) ? lowest(err_pulse) : lowest(warn_pulse);
  end
`else
  always_comb begin
    trip       = (err_sat >= ERR_LIM);
    first_next = lowest(err_pulse);
  end
`endif

  // The arming edge itself already counts events, so counting starts HOLDOFF+1 edges after reset.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    err_d     = err_q;
    warn_d    = warn_q;
    first_d   = first_q;
    note_d    = 1'b0;
    hold_done = (state_q == S_HOLD) && (hold_q == HOLD_LIM);
    count_en  = (state_q != S_HOLD) || hold_done;

    if (state_q == S_HOLD) begin
      if (hold_done) state_d = S_ARMED;
      else           hold_d  = hold_q + 16'd1;
    end

    if ((state_q != S_HOLD) && clear) begin
      err_d   = '0;
      warn_d  = '0;
      first_d = '0;
      state_d = S_ARMED;
    end else if (count_en) begin
      err_d  = err_sat;
      warn_d = warn_sat;
      note_d = (warn_q == '0) && (warn_sat != '0);
      if ((state_q != S_TRIPPED) && trip) begin
        state_d = S_TRIPPED;
        first_d = first_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      err_q   <= '0;
      warn_q  <= '0;
      first_q <= '0;
      note_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      warn_q  <= warn_d;
      first_q <= first_d;
      note_q  <= note_d;
    end
  end

  assign errors     = err_q;
  assign warnings   = warn_q;
  assign message_on = (state_q != S_HOLD);
  assign stop_req   = (state_q == S_TRIPPED);
  assign first_chan = first_q;
  assign warn_note  = note_q;
  assign state_o    = state_q;

endmodule
